// File: rtl/squeeze_serializer.sv
// Sponge squeeze serializer: splits INWIDTH blocks into OUTWIDTH words, LS word first, and requests more blocks until out_len words are sent.
// Latency: first word one cycle after the block is accepted. Backpressure: out_ready=0 holds the current word.
module squeeze_serializer #(
  parameter int INWIDTH  = 256,
  parameter int OUTWIDTH = 8,
  parameter int LENWIDTH = 16
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                start,
  input  logic [LENWIDTH-1:0] out_len,
  output logic                squeeze_req,
  input  logic [INWIDTH-1:0]  block_in,
  input  logic                block_valid,
  output logic                block_ready,
  output logic [OUTWIDTH-1:0] serial_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  localparam int N  = INWIDTH / OUTWIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BLK, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [INWIDTH-1:0]  shreg_q;
  logic [LENWIDTH-1:0] rem_q;
  logic [CW-1:0]       wcnt_q;
  logic                load_len, load_blk, take_word, req_d, done_d;

  always_comb begin
    state_d   = state_q;
    load_len  = 1'b0;
    load_blk  = 1'b0;
    take_word = 1'b0;
    req_d     = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (out_len != '0) begin
            load_len = 1'b1;
            req_d    = 1'b1;
            state_d  = WAIT_BLK;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_BLK: begin
        if (block_valid) begin
          load_blk = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          take_word = 1'b1;
          // Length exhaustion wins over block exhaustion so no spare block is requested.
          if (rem_q == LENWIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (wcnt_q == CW'(N - 1)) begin
            req_d   = 1'b1;
            state_d = WAIT_BLK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign block_ready = (state_q == WAIT_BLK);
  assign out_valid   = (state_q == SHIFT);
  assign busy        = (state_q != IDLE);
  assign serial_out  = shreg_q[OUTWIDTH-1:0];

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      shreg_q     <= '0;
      rem_q       <= '0;
      wcnt_q      <= '0;
      squeeze_req <= 1'b0;
      done        <= 1'b0;
    end else begin
      squeeze_req <= req_d;
      done        <= done_d;
      if (load_len) rem_q <= out_len;
      if (load_blk) begin
        shreg_q <= block_in;
        wcnt_q  <= '0;
      end
      if (take_word) begin
        shreg_q <= shreg_q >> OUTWIDTH;
        wcnt_q  <= wcnt_q + 1'b1;
        if (rem_q != '0) rem_q <= rem_q - 1'b1;
      end
    end
  end

endmodule
